rr_arbiter_mux: RTL and testbench
=================================

RR_ARBITER_MUX -- requirements
Module: rr_arbiter_mux

Interface
REQ-001 Parameter N_CH, default 4, number of input channels; legal range 2..16.
REQ-002 Parameter WIDTH, default 8, data bits per channel; legal range 1..64.
REQ-003 Derived CW = $clog2(N_CH), width of the channel index.
REQ-004 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 Port rst, input, 1, synchronous, active-high reset.
REQ-006 Port in_valid, input, N_CH, bit i set = channel i offers data.
REQ-007 Port in_data, input, N_CH*WIDTH, channel i data at bits [i*WIDTH +: WIDTH].
REQ-008 Port in_ready, output, N_CH, bit i set = channel i transfer accepted this cycle.
REQ-009 Port out_valid, output, 1, out_data/out_ch hold a valid word.
REQ-010 Port out_data, output, WIDTH, selected word.
REQ-011 Port out_ch, output, CW, index of the channel that supplied out_data.
REQ-012 Port out_ready, input, 1, downstream accepts the word when high with out_valid.

Function
REQ-013 Transfer on any port SHALL occur only when valid and ready are both high at a rising clk edge.
REQ-014 Output stage SHALL be a single registered slot; out_data, out_ch, out_valid driven directly from flops.
REQ-015 Slot "free" SHALL mean out_valid==0 or out_ready==1 (combinational, same cycle).
REQ-016 When slot free and any in_valid set, exactly one in_ready bit SHALL be high: the granted channel; otherwise in_ready SHALL be all zero.
REQ-017 in_ready SHALL depend combinationally on in_valid, out_valid, out_ready and the pointer only, never on in_data.
REQ-018 Grant SHALL be round-robin: search starts at channel (last+1) mod N_CH and proceeds upward with wrap-around; first channel with in_valid set wins.
REQ-019 last SHALL update to the granted index only on an accepted input transfer; unchanged otherwise.
REQ-020 On grant, the next edge SHALL load out_data = in_data of granted channel, out_ch = granted index, out_valid = 1; latency input-accept to out_valid = 1 cycle.
REQ-021 When slot free and no in_valid set, out_valid SHALL go to 0 at the next edge; out_data and out_ch hold their last values.
REQ-022 When out_valid==1 and out_ready==0, out_data, out_ch, out_valid SHALL hold stable and in_ready SHALL be all zero (backpressure).
REQ-023 Simultaneous output consume and input grant in one cycle SHALL sustain one word per cycle with no bubble.
REQ-024 A single continuously requesting channel SHALL be granted every cycle the slot is free.
REQ-025 With all N_CH channels requesting continuously and out_ready=1, each channel SHALL be granted exactly once every N_CH cycles (starvation-free).
REQ-026 Dropping in_valid on a non-granted channel SHALL have no side effect; no word is lost or duplicated.

Reset
REQ-027 While rst high at an edge: out_valid=0, out_data=0, out_ch=0, last=N_CH-1 (so channel 0 has first priority).
REQ-028 While rst high, in_ready SHALL be all zero; no input transfer occurs.
REQ-029 Reset asserted mid-operation SHALL discard the slot contents; first post-reset grant follows REQ-027 priority.

Verification
REQ-030 Reset, then in_valid=4'b1111, data ch i = 8'h10+i, out_ready=1 -> out_ch sequence 0,1,2,3,0,... with out_data 10,11,12,13,10, one word per cycle after 1-cycle latency.
REQ-031 Only ch2 valid (data 8'hA5), out_ready=1 -> in_ready=4'b0100 every cycle, out_valid continuous, out_ch=2, out_data=A5.
REQ-032 Word loaded from ch1 (8'h3C), out_ready=0 for 5 cycles with in_valid=4'b1111 -> out_data=3C, out_ch=1 stable, in_ready=0 throughout; on out_ready=1, next grant is ch2.
REQ-033 in_valid=4'b1001 after last grant ch0 -> next grant ch3, then ch0; wrap-around verified.
REQ-034 rst pulsed while out_valid=1 and in_valid=4'b0110 -> out_valid=0 during reset; first post-reset grant ch1.
REQ-035 Random in_valid, in_data, out_ready over 10k cycles -> scoreboard confirms no loss, no duplication, per-channel order preserved, outputs stable under backpressure.

Source files
------------

// File: rtl/rr_arbiter_mux.sv
// rr_arbiter_mux: round-robin N_CH-to-1 arbiter feeding a single registered output slot.
module rr_arbiter_mux #(
  parameter int N_CH = 4,
  parameter int WIDTH = 8,
  localparam int CW = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [CW-1:0]         out_ch,
  input  logic                  out_ready
);
  logic free, found, take;
  logic [CW-1:0] gnt, last_q, last_d, out_ch_q, out_ch_d;
  logic out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  int j;
  // search upward from last+1 with wrap; the first requester found wins
  always_comb begin
    found = 1'b0;
    gnt = last_q;
    j = 0;
    for (int k = 1; k <= N_CH; k++) begin
      j = int'(last_q) + k;
      j = (j >= N_CH) ? j - N_CH : j;
      if (!found && in_valid[CW'(j)]) begin
        found = 1'b1;
        gnt = CW'(j);
      end
    end
  end
  assign free = !out_valid_q || out_ready;
  assign take = free && found && !rst;
  assign in_ready = take ? {{(N_CH-1){1'b0}}, 1'b1} << gnt : '0;
  always_comb begin
    out_valid_d = free ? found : out_valid_q;
    out_data_d = take ? in_data[gnt*WIDTH +: WIDTH] : out_data_q;
    out_ch_d = take ? gnt : out_ch_q;
    last_d = take ? gnt : last_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_ch_q <= '0;
      last_q <= CW'(N_CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_ch_q <= out_ch_d;
      last_q <= last_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_ch = out_ch_q;
endmodule

// File: tb/tb_rr_arbiter_mux.sv
// tb_rr_arbiter_mux: directed vectors plus a random phase, checked against a spec-level model and a scoreboard.
module tb_rr_arbiter_mux;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] in_valid, in_ready;
  logic [N*W-1:0] in_data;
  logic out_valid, out_ready;
  logic [W-1:0] out_data;
  logic [1:0] out_ch;
  int total = 0;
  int passed = 0;

  rr_arbiter_mux #(.N_CH(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else passed++;
  endtask

  function automatic int exp_grant(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // model: one slot plus the index of the last accepted channel
  logic m_valid = 1'b0;
  logic [W-1:0] m_data = '0;
  int m_ch = 0;
  int m_last = N - 1;
  int mg;
  logic [N-1:0] exp_rdy;
  always_comb begin
    mg = exp_grant(m_last, in_valid);
    exp_rdy = (!rst && (!m_valid || out_ready) && mg >= 0) ? N'(1) << mg : '0;
  end
  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data <= '0;
      m_ch <= 0;
      m_last <= N - 1;
    end else if (!m_valid || out_ready) begin
      m_valid <= mg >= 0;
      if (mg >= 0) begin
        m_data <= in_data[mg*W +: W];
        m_ch <= mg;
        m_last <= mg;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_in_ready", in_ready, exp_rdy);
    chk("m_out_valid", out_valid, m_valid);
    chk("m_out_data", out_data, m_data);
    chk("m_out_ch", out_ch, m_ch);
  end

  int sb_ch[$];
  logic [W-1:0] sb_d[$];
  always @(negedge clk) begin
    if (rst) begin
      sb_ch.delete();
      sb_d.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk("sb_nonempty", sb_d.size() > 0, 1);
        if (sb_d.size() > 0) begin
          chk("sb_ch", out_ch, sb_ch.pop_front());
          chk("sb_data", out_data, sb_d.pop_front());
        end
      end
      for (int i = 0; i < N; i++)
        if (in_valid[i] && in_ready[i]) begin
          sb_ch.push_back(i);
          sb_d.push_back(in_data[i*W +: W]);
        end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 4'b1111;
    in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    out_ready = 1'b1;
    tick();
    smp();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_in_ready", in_ready, 4'b0000);
    tick();
    rst = 1'b0;
    smp();
    chk("rr_first_ready", in_ready, 4'b0001);
    chk("rr_latency", out_valid, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      smp();
      chk("rr_valid", out_valid, 1);
      chk("rr_ch", out_ch, k % 4);
      chk("rr_data", out_data, 8'h10 + k % 4);
      chk("rr_ready", in_ready, 4'b0001 << ((k + 1) % 4));
    end
    tick();
    in_valid = 4'b0100;
    in_data[2*W +: W] = 8'hA5;
    smp();
    chk("solo_ready0", in_ready, 4'b0100);
    for (int k = 0; k < 3; k++) begin
      tick();
      smp();
      chk("solo_valid", out_valid, 1);
      chk("solo_ch", out_ch, 2);
      chk("solo_data", out_data, 8'hA5);
      chk("solo_ready", in_ready, 4'b0100);
    end
    tick();
    in_valid = 4'b0010;
    in_data[1*W +: W] = 8'h3C;
    smp();
    chk("bp_load_ready", in_ready, 4'b0010);
    tick();
    out_ready = 1'b0;
    in_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("bp_valid", out_valid, 1);
      chk("bp_ch", out_ch, 1);
      chk("bp_data", out_data, 8'h3C);
      chk("bp_ready", in_ready, 4'b0000);
      tick();
    end
    out_ready = 1'b1;
    smp();
    chk("bp_next_ready", in_ready, 4'b0100);
    tick();
    smp();
    chk("bp_next_ch", out_ch, 2);
    tick();
    in_valid = 4'b0001;
    smp();
    chk("wrap_pre", in_ready, 4'b0001);
    tick();
    in_valid = 4'b1001;
    smp();
    chk("wrap_ready3", in_ready, 4'b1000);
    chk("wrap_ch0", out_ch, 0);
    tick();
    smp();
    chk("wrap_ch3", out_ch, 3);
    chk("wrap_ready0", in_ready, 4'b0001);
    tick();
    smp();
    chk("wrap_back_ch0", out_ch, 0);
    tick();
    in_valid = 4'b0110;
    rst = 1'b1;
    smp();
    chk("mid_rst_ready", in_ready, 4'b0000);
    chk("mid_rst_pre_valid", out_valid, 1);
    tick();
    smp();
    chk("mid_rst_valid", out_valid, 0);
    tick();
    rst = 1'b0;
    smp();
    chk("post_rst_ready", in_ready, 4'b0010);
    tick();
    smp();
    chk("post_rst_ch", out_ch, 1);
    chk("post_rst_data", out_data, 8'h3C);
    for (int k = 0; k < 10000; k++) begin
      tick();
      rst = ($urandom_range(0, 499) == 0);
      in_valid = N'($urandom_range(0, 15));
      in_data = {$urandom(), $urandom()};
      out_ready = ($urandom_range(0, 3) != 0);
    end
    tick();
    rst = 1'b0;
    in_valid = '0;
    out_ready = 1'b1;
    tick();
    tick();
    smp();
    chk("drain_empty", sb_d.size(), 0);
    chk("drain_valid", out_valid, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
